// File: rtl/uart_packet_parser.sv
// Receive-side framing stage: splits the UART byte stream into echo bytes
// and 32-bit little-endian ALU operands, draining malformed packets.
//
// state  | meaning
// -------+-----------------------------------------------------------
// OPCODE | waiting for the first header byte; latches the opcode
// RSVD   | reserved header byte, discarded
// LEN_LO | low byte of the packet length
// LEN_HI | high byte of the length; classifies the packet
// ECHO   | payload passes straight through to the echo port
// GATHER | payload bytes assembled into an operand word
// OUT    | operand presented to the ALU, input stalled
// DRAIN  | payload of a malformed packet discarded
module uart_packet_parser #(
  parameter int DATA_WIDTH_P = 8,
  parameter int WORD_WIDTH_P = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH_P-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH_P-1:0] echo_tdata,
  output logic                    echo_tvalid,
  input  logic                    echo_tready,
  output logic [DATA_WIDTH_P-1:0] op_o,
  output logic [WORD_WIDTH_P-1:0] operand_tdata,
  output logic                    operand_tvalid,
  output logic                    operand_tlast,
  input  logic                    operand_tready,
  output logic                    frame_error_o
);

  localparam int LEN_W = 2 * DATA_WIDTH_P;
  localparam int BPW   = WORD_WIDTH_P / DATA_WIDTH_P;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [DATA_WIDTH_P-1:0] OP_ECHO = DATA_WIDTH_P'(8'hEC);
  localparam logic [DATA_WIDTH_P-1:0] OP_ADD  = DATA_WIDTH_P'(8'hA0);
  localparam logic [DATA_WIDTH_P-1:0] OP_MUL  = DATA_WIDTH_P'(8'hA1);
  localparam logic [DATA_WIDTH_P-1:0] OP_DIV  = DATA_WIDTH_P'(8'hA2);
  localparam logic [LEN_W-1:0]        HDR_LEN = LEN_W'(4);
  localparam logic [LEN_W-1:0]        MIN_ARITH = LEN_W'(8);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(BPW - 1);

  typedef enum logic [2:0] {
    OPCODE,
    RSVD,
    LEN_LO,
    LEN_HI,
    ECHO,
    GATHER,
    OUT,
    DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH_P-1:0] op_q, op_d;
  logic [DATA_WIDTH_P-1:0] len_lo_q, len_lo_d;
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic [WORD_WIDTH_P-1:0] operand_q, operand_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    frame_err_q, frame_err_d;

  logic                    tready_c;
  logic                    echo_tvalid_c;
  logic [DATA_WIDTH_P-1:0] echo_tdata_c;
  logic                    opnd_valid_c;
  logic [LEN_W-1:0]        len_full;
  logic [LEN_W-1:0]        rem_calc;
  logic                    is_arith;

  assign len_full = {s_axis_tdata, len_lo_q};
  assign rem_calc = len_full - HDR_LEN;
  assign is_arith = (op_q == OP_ADD) || (op_q == OP_MUL) || (op_q == OP_DIV);

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    len_lo_d      = len_lo_q;
    rem_d         = rem_q;
    operand_d     = operand_q;
    cnt_d         = cnt_q;
    frame_err_d   = 1'b0;
    tready_c      = 1'b0;
    echo_tvalid_c = 1'b0;
    echo_tdata_c  = '0;
    opnd_valid_c  = 1'b0;

    case (state_q)
      OPCODE: begin
        tready_c = 1'b1;
        if (s_axis_tvalid) begin
          op_d    = s_axis_tdata;
          state_d = RSVD;
        end
      end
      RSVD: begin
        tready_c = 1'b1;
        if (s_axis_tvalid) state_d = LEN_LO;
      end
      LEN_LO: begin
        tready_c = 1'b1;
        if (s_axis_tvalid) begin
          len_lo_d = s_axis_tdata;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        tready_c = 1'b1;
        if (s_axis_tvalid) begin
          rem_d = rem_calc;
          cnt_d = '0;
          // Short length is checked first so rem_calc never wraps when used.
          if (len_full < HDR_LEN) begin
            frame_err_d = 1'b1;
            state_d     = OPCODE;
          end else if (op_q == OP_ECHO) begin
            state_d = (rem_calc == '0) ? OPCODE : ECHO;
          end else if (is_arith && (rem_calc[1:0] == 2'b00) && (rem_calc >= MIN_ARITH)) begin
            state_d = GATHER;
          end else begin
            frame_err_d = 1'b1;
            state_d     = (rem_calc != '0) ? DRAIN : OPCODE;
          end
        end
      end
      ECHO: begin
        tready_c      = echo_tready;
        echo_tvalid_c = s_axis_tvalid;
        echo_tdata_c  = s_axis_tdata;
        if (s_axis_tvalid && echo_tready) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = OPCODE;
        end
      end
      GATHER: begin
        tready_c = 1'b1;
        if (s_axis_tvalid) begin
          operand_d = {s_axis_tdata, operand_q[WORD_WIDTH_P-1:DATA_WIDTH_P]};
          rem_d     = rem_q - LEN_W'(1);
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = OUT;
        end
      end
      OUT: begin
        opnd_valid_c = 1'b1;
        if (operand_tready) begin
          cnt_d   = '0;
          state_d = (rem_q != '0) ? GATHER : OPCODE;
        end
      end
      DRAIN: begin
        tready_c = 1'b1;
        if (s_axis_tvalid) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = OPCODE;
        end
      end
      default: state_d = OPCODE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= OPCODE;
      op_q        <= '0;
      len_lo_q    <= '0;
      rem_q       <= '0;
      operand_q   <= '0;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_lo_q    <= len_lo_d;
      rem_q       <= rem_d;
      operand_q   <= operand_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Combinational outputs are gated so everything reads 0 while rst is held.
  assign s_axis_tready  = tready_c & ~rst;
  assign echo_tvalid    = echo_tvalid_c & ~rst;
  assign echo_tdata     = rst ? '0 : echo_tdata_c;
  assign operand_tvalid = opnd_valid_c & ~rst;
  assign operand_tlast  = opnd_valid_c & ~rst & (rem_q == '0);
  assign operand_tdata  = operand_q;
  assign op_o           = op_q;
  assign frame_error_o  = frame_err_q;

endmodule

// File: tb/tb_uart_packet_parser.sv
// Scoreboard bench for uart_packet_parser: directed packets followed by
// random traffic with random gaps and backpressure on both outputs.
module tb_uart_packet_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  echo_tdata;
  logic        echo_tvalid;
  logic        echo_tready = 1'b1;
  logic [7:0]  op_o;
  logic [31:0] operand_tdata;
  logic        operand_tvalid;
  logic        operand_tlast;
  logic        operand_tready = 1'b1;
  logic        frame_error_o;

  always #5 clk = ~clk;

  uart_packet_parser #(.DATA_WIDTH_P(8), .WORD_WIDTH_P(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .echo_tdata     (echo_tdata),
    .echo_tvalid    (echo_tvalid),
    .echo_tready    (echo_tready),
    .op_o           (op_o),
    .operand_tdata  (operand_tdata),
    .operand_tvalid (operand_tvalid),
    .operand_tlast  (operand_tlast),
    .operand_tready (operand_tready),
    .frame_error_o  (frame_error_o)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [7:0]  op;
  } opnd_t;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_echo[$];
  opnd_t      exp_opnd[$];
  int         exp_err[$];
  bit         rand_mode = 0;
  bit         hold_opnd = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string detail);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // Reference model: what a whole packet should produce, from the framing rules.
  function automatic void model(input logic [7:0] p[$]);
    int len;
    int rem;
    opnd_t o;
    len = int'({p[3], p[2]});
    if (len < 4) begin
      exp_err.push_back(1);
      return;
    end
    rem = len - 4;
    if (p[0] == 8'hEC) begin
      for (int i = 0; i < rem; i++) exp_echo.push_back(p[4 + i]);
      return;
    end
    if ((p[0] inside {8'hA0, 8'hA1, 8'hA2}) && (rem % 4 == 0) && (rem >= 8)) begin
      for (int w = 0; w < rem / 4; w++) begin
        o.data = {p[7 + 4*w], p[6 + 4*w], p[5 + 4*w], p[4 + 4*w]};
        o.last = (w == rem / 4 - 1);
        o.op   = p[0];
        exp_opnd.push_back(o);
      end
      return;
    end
    exp_err.push_back(1);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (rand_mode) begin
        echo_tready    = ($urandom_range(0, 3) != 0);
        operand_tready = hold_opnd ? 1'b0 : ($urandom_range(0, 3) != 0);
      end else begin
        echo_tready    = 1'b1;
        operand_tready = !hold_opnd;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    if (rand_mode && $urandom_range(0, 4) == 0) begin
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'($urandom);
    end
    @(negedge clk);
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    #1;
    while (!s_axis_tready) begin
      @(negedge clk);
      #1;
      guard++;
      if (guard > 200) begin
        flag("tready_timeout", "got tready 0 for 200 cycles, expected 1");
        s_axis_tvalid = 1'b0;
        return;
      end
    end
    @(posedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] p[$], input bit use_model);
    if (use_model) model(p);
    foreach (p[i]) send_byte(p[i]);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic make_pkt(input logic [7:0] op, input int len, output logic [7:0] p[$]);
    int n;
    p = {};
    p.push_back(op);
    p.push_back(8'($urandom));
    p.push_back(len[7:0]);
    p.push_back(len[15:8]);
    n = (len < 4) ? 0 : len - 4;
    for (int i = 0; i < n; i++) p.push_back(8'($urandom));
  endtask

  // Monitor: outputs sampled mid-cycle, after inputs have settled.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [7:0]  e;
    opnd_t       o;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 1'b0;
        continue;
      end
      if (echo_tvalid && echo_tready) begin
        if (exp_echo.size() == 0) flag("echo_extra", $sformatf("got %h expected none", echo_tdata));
        else begin
          e = exp_echo.pop_front();
          check("echo_tdata", {24'h0, echo_tdata}, {24'h0, e});
        end
      end
      if (operand_tvalid) begin
        if (prev_stall) begin
          check("opnd_hold_data", operand_tdata, prev_data);
          check("opnd_hold_last", {31'h0, operand_tlast}, {31'h0, prev_last});
          check("stall_tready", {31'h0, s_axis_tready}, 32'h0);
        end
        if (operand_tready) begin
          if (exp_opnd.size() == 0) flag("opnd_extra", $sformatf("got %h expected none", operand_tdata));
          else begin
            o = exp_opnd.pop_front();
            check("opnd_data", operand_tdata, o.data);
            check("opnd_last", {31'h0, operand_tlast}, {31'h0, o.last});
            check("op_o", {24'h0, op_o}, {24'h0, o.op});
          end
        end
        prev_stall = !operand_tready;
        prev_data  = operand_tdata;
        prev_last  = operand_tlast;
      end else begin
        if (prev_stall) flag("opnd_dropped", "got tvalid 0 expected 1 while stalled");
        prev_stall = 1'b0;
      end
      if (frame_error_o) begin
        if (exp_err.size() == 0) flag("frame_error_extra", "got 1 expected 0");
        else void'(exp_err.pop_front());
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_tready"}, {31'h0, s_axis_tready}, 32'h0);
    check({tag, "_echo_tvalid"}, {31'h0, echo_tvalid}, 32'h0);
    check({tag, "_echo_tdata"}, {24'h0, echo_tdata}, 32'h0);
    check({tag, "_opnd_tvalid"}, {31'h0, operand_tvalid}, 32'h0);
    check({tag, "_opnd_tlast"}, {31'h0, operand_tlast}, 32'h0);
    check({tag, "_opnd_tdata"}, operand_tdata, 32'h0);
    check({tag, "_op_o"}, {24'h0, op_o}, 32'h0);
    check({tag, "_frame_error"}, {31'h0, frame_error_o}, 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p[$];
    int guard;
    int kind;
    int len;
    logic [7:0] op;

    repeat (3) @(negedge clk);
    #2;
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    #2;
    check("tready_after_reset", {31'h0, s_axis_tready}, 32'h1);

    p = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
    send_pkt(p, 1);
    p = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    send_pkt(p, 1);

    // Hold the first operand for 5 cycles; the monitor checks it stays put.
    hold_opnd = 1'b1;
    fork
      send_pkt(p, 1);
    join_none
    guard = 0;
    do begin
      @(negedge clk);
      #2;
      guard++;
    end while (!operand_tvalid && guard < 100);
    if (!operand_tvalid) flag("bp_tvalid_timeout", "got tvalid 0 expected 1");
    repeat (5) @(negedge clk);
    hold_opnd = 1'b0;
    wait fork;

    p = '{8'hA1, 8'h00, 8'h09, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_pkt(p, 1);
    p = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7F};
    send_pkt(p, 1);
    p = '{8'h55, 8'h00, 8'h03, 8'h00};
    send_pkt(p, 1);
    p = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    send_pkt(p, 1);
    p = '{8'hEC, 8'h00, 8'h04, 8'h00};
    send_pkt(p, 1);

    // Abandon an add packet after two operand bytes.
    p = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02};
    send_pkt(p, 0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("midrst_tready", {31'h0, s_axis_tready}, 32'h0);
    @(negedge clk);
    #2;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #2;
    check("midrst_tready_release", {31'h0, s_axis_tready}, 32'h1);
    p = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h33};
    send_pkt(p, 1);

    rand_mode = 1'b1;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 3) begin
        op  = 8'hEC;
        len = $urandom_range(4, 20);
      end else if (kind <= 6) begin
        op  = 8'hA0 + 8'($urandom_range(0, 2));
        len = 4 + 4 * $urandom_range(2, 4);
      end else begin
        case ($urandom_range(0, 2))
          0: op = 8'hA0 + 8'($urandom_range(0, 2));
          1: op = 8'h55;
          default: op = 8'($urandom);
        endcase
        len = $urandom_range(0, 20);
      end
      make_pkt(op, len, p);
      send_pkt(p, 1);
    end
    rand_mode = 1'b0;

    guard = 0;
    while ((exp_echo.size() + exp_opnd.size() + exp_err.size()) != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check("pending_echo", exp_echo.size(), 0);
    check("pending_opnd", exp_opnd.size(), 0);
    check("pending_err", exp_err.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
